// File: rtl/wave_pkg.sv
// Shared types and default widths for the sample-rate waveform generator.
package wave_pkg;

  localparam int PHASE_W_DEF = 16;
  localparam int OUT_W_DEF   = 12;

  typedef enum logic [1:0] {
    SHAPE_SQUARE = 2'd0,
    SHAPE_SAW    = 2'd1,
    SHAPE_TRI    = 2'd2,
    SHAPE_DC     = 2'd3
  } shape_t;

endpackage

// File: rtl/wave_sample_gen_if.sv
// Configuration ready/valid channel for wave_sample_gen.
interface wave_sample_gen_if
  import wave_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int OUT_W   = OUT_W_DEF
) ();

  logic               cfg_valid;
  logic               cfg_ready;
  shape_t             cfg_shape;
  logic [PHASE_W-1:0] cfg_step;
  logic [OUT_W:0]     cfg_amp;
  logic               cfg_phase_rst;

  modport master (
    output cfg_valid, cfg_shape, cfg_step, cfg_amp, cfg_phase_rst,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_shape, cfg_step, cfg_amp, cfg_phase_rst,
    output cfg_ready
  );

endinterface

// File: rtl/wave_shaper.sv
// Combinational waveform lookup and gain stage: top phase bits, shape and amp -> scaled sample.
module wave_shaper
  import wave_pkg::*;
#(
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic [OUT_W:0]   i_phase_hi,
  input  shape_t           i_shape,
  input  logic [OUT_W:0]   i_amp,
  output logic [OUT_W-1:0] o_sample
);

  localparam int             PROD_W = 2 * OUT_W + 1;
  localparam logic [OUT_W:0] UNITY  = {1'b1, {OUT_W{1'b0}}};

  logic             w_msb;
  logic [OUT_W-1:0] w_saw;
  logic [OUT_W-1:0] w_tri;
  logic [OUT_W-1:0] w_raw;
  logic [OUT_W:0]   w_gain;
  logic [PROD_W-1:0] w_prod;

  // Only the OUT_W+1 most significant phase bits ever reach the waveform.
  assign w_msb = i_phase_hi[OUT_W];
  assign w_saw = i_phase_hi[OUT_W:1];
  assign w_tri = i_phase_hi[OUT_W-1:0];

  always_comb begin
    // NOTE: default assignment first so every path drives w_raw; no latch is inferred.
    w_raw = '0;
    case (i_shape)
      SHAPE_SQUARE: w_raw = {OUT_W{w_msb}};
      SHAPE_SAW:    w_raw = w_saw;
      SHAPE_TRI:    w_raw = w_msb ? ~w_tri : w_tri;
      SHAPE_DC:     w_raw = {1'b1, {(OUT_W-1){1'b0}}};
      default:      w_raw = '0;
    endcase
  end

  assign w_gain   = (i_amp > UNITY) ? UNITY : i_amp;
  assign w_prod   = PROD_W'(w_raw) * PROD_W'(w_gain);
  assign o_sample = OUT_W'(w_prod >> OUT_W);

endmodule

// File: rtl/wave_sample_gen.sv
// Tick-driven phase accumulator with glitch-free config apply and a registered,
// amplitude-scaled waveform output one clock after each tick.
module wave_sample_gen
  import wave_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int OUT_W   = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_tick,
  input  logic             i_enable,
  wave_sample_gen_if.slave cfg_if,
  output logic [OUT_W-1:0] o_sample,
  output logic             o_sample_valid,
  output logic             o_wrap
);

  // Shadow copy of an accepted config, waiting for the next tick.
  logic               r_pending;
  shape_t             r_sh_shape;
  logic [PHASE_W-1:0] r_sh_step;
  logic [OUT_W:0]     r_sh_amp;
  logic               r_sh_phase_rst;

  shape_t             r_shape;
  logic [PHASE_W-1:0] r_step;
  logic [OUT_W:0]     r_amp;

  logic [PHASE_W-1:0] r_phase;
  logic               r_s1_valid;
  logic               r_s1_wrap;

  logic               w_accept;
  logic               w_apply;
  logic [PHASE_W-1:0] w_step;
  logic [PHASE_W:0]   w_sum;
  logic [OUT_W-1:0]   w_shaped;

  assign cfg_if.cfg_ready = !r_pending;
  assign w_accept = cfg_if.cfg_valid && !r_pending;
  // A config accepted on a tick cycle is not yet pending, so it waits for the next tick.
  assign w_apply  = i_tick && r_pending;
  assign w_step   = w_apply ? r_sh_step : r_step;
  assign w_sum    = {1'b0, r_phase} + {1'b0, w_step};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending      <= 1'b0;
      r_sh_shape     <= SHAPE_SAW;
      r_sh_step      <= '0;
      r_sh_amp       <= '0;
      r_sh_phase_rst <= 1'b0;
      r_shape        <= SHAPE_SAW;
      r_step         <= '0;
      r_amp          <= '0;
      r_phase        <= '0;
      r_s1_valid     <= 1'b0;
      r_s1_wrap      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sh_shape     <= cfg_if.cfg_shape;
        r_sh_step      <= cfg_if.cfg_step;
        r_sh_amp       <= cfg_if.cfg_amp;
        r_sh_phase_rst <= cfg_if.cfg_phase_rst;
      end

      if (w_apply) begin
        r_pending <= 1'b0;
        r_shape   <= r_sh_shape;
        r_step    <= r_sh_step;
        r_amp     <= r_sh_amp;
      end else if (w_accept) begin
        r_pending <= 1'b1;
      end

      r_s1_valid <= i_tick && i_enable;
      r_s1_wrap  <= 1'b0;
      if (i_tick) begin
        if (w_apply && r_sh_phase_rst) begin
          r_phase <= '0;
        end else if (i_enable) begin
          r_phase   <= w_sum[PHASE_W-1:0];
          r_s1_wrap <= w_sum[PHASE_W];
        end
      end
    end
  end

  wave_shaper #(
    .OUT_W (OUT_W)
  ) u_shaper (
    .i_phase_hi (r_phase[PHASE_W-1 -: OUT_W+1]),
    .i_shape    (r_shape),
    .i_amp      (r_amp),
    .o_sample   (w_shaped)
  );

  // Output stage: sample holds its last value between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_sample       <= '0;
      o_sample_valid <= 1'b0;
      o_wrap         <= 1'b0;
    end else begin
      o_sample_valid <= r_s1_valid;
      o_wrap         <= r_s1_wrap;
      if (r_s1_valid) begin
        o_sample <= w_shaped;
      end
    end
  end

endmodule

// File: tb/tb_wave_sample_gen.sv
// Scoreboard bench for wave_sample_gen: expected samples are queued when ticks are driven
// and compared when sample_valid strobes.
module tb_wave_sample_gen;
  import wave_pkg::*;

  localparam int PW = 16;
  localparam int OW = 12;

  typedef struct {
    logic [OW-1:0] s;
    logic          w;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          i_tick;
  logic          i_enable;
  logic [OW-1:0] o_sample;
  logic          o_sample_valid;
  logic          o_wrap;

  int   n_total = 0;
  int   n_bad   = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  logic [OW-1:0] sq_tab[4]  = '{12'h000, 12'h7FF, 12'h7FF, 12'h000};
  logic [OW-1:0] tri_tab[8] = '{12'h400, 12'h800, 12'hC00, 12'hFFF,
                                12'hBFF, 12'h7FF, 12'h3FF, 12'h000};

  wave_sample_gen_if #(.PHASE_W(PW), .OUT_W(OW)) cfg_if ();

  wave_sample_gen #(
    .PHASE_W (PW),
    .OUT_W   (OW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_tick         (i_tick),
    .i_enable       (i_enable),
    .cfg_if         (cfg_if),
    .o_sample       (o_sample),
    .o_sample_valid (o_sample_valid),
    .o_wrap         (o_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drives tick for one cycle from a negedge; leaves i_tick high so ticks can run back-to-back.
  task automatic expect_tick(input logic v, input logic [OW-1:0] s, input logic w);
    exp_t e;
    if (v) begin
      e.s = s;
      e.w = w;
      exp_q.push_back(e);
    end
    i_tick = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    i_tick = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_cfg(input shape_t sh, input logic [PW-1:0] st,
                          input logic [OW:0] am, input logic pr);
    int n = 0;
    cfg_if.cfg_shape     = sh;
    cfg_if.cfg_step      = st;
    cfg_if.cfg_amp       = am;
    cfg_if.cfg_phase_rst = pr;
    cfg_if.cfg_valid     = 1'b1;
    while (!cfg_if.cfg_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("cfg_ready_wait", 32'(cfg_if.cfg_ready), 1);
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
  endtask

  initial begin
    rst_n                = 1'b0;
    i_tick               = 1'b0;
    i_enable             = 1'b1;
    cfg_if.cfg_valid     = 1'b0;
    cfg_if.cfg_shape     = SHAPE_SAW;
    cfg_if.cfg_step      = '0;
    cfg_if.cfg_amp       = '0;
    cfg_if.cfg_phase_rst = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (o_sample_valid) begin
            if (exp_q.size() == 0) begin
              check("spurious_valid", 32'(o_sample_valid), 0);
            end else begin
              mon_e = exp_q.pop_front();
              check("sample", 32'(o_sample), 32'(mon_e.s));
              check("wrap", 32'(o_wrap), 32'(mon_e.w));
            end
          end else if (o_wrap) begin
            check("wrap_without_valid", 32'(o_wrap), 0);
          end
        end
      end
      begin
        #500000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset held while ticks arrive.
    repeat (4) begin
      @(negedge clk);
      i_tick = ~i_tick;
    end
    @(negedge clk);
    check("rst_sample", 32'(o_sample), 0);
    check("rst_valid", 32'(o_sample_valid), 0);
    check("rst_wrap", 32'(o_wrap), 0);
    check("rst_ready", 32'(cfg_if.cfg_ready), 1);
    i_tick = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    idle(3);
    check("idle_no_valid", 32'(o_sample_valid), 0);

    // Sawtooth, spaced ticks.
    send_cfg(SHAPE_SAW, 16'h1000, 13'h1000, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      expect_tick(1'b1, OW'((i % 16) * 256), i == 16);
      idle(1);
    end
    idle(2);

    // Square at half gain, back-to-back ticks.
    send_cfg(SHAPE_SQUARE, 16'h4000, 13'h0800, 1'b0);
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 4; j++) begin
        expect_tick(1'b1, sq_tab[j], j == 3);
      end
    end
    idle(2);

    // Triangle at unity, back-to-back ticks.
    send_cfg(SHAPE_TRI, 16'h2000, 13'h1000, 1'b0);
    for (int j = 0; j < 8; j++) begin
      expect_tick(1'b1, tri_tab[j], j == 7);
    end
    idle(2);

    // Handshake: config A pending holds ready low, B is held off until A applies.
    send_cfg(SHAPE_SAW, 16'h1000, 13'h1000, 1'b0);
    repeat (2) begin
      check("ready_low_pending", 32'(cfg_if.cfg_ready), 0);
      @(negedge clk);
    end
    cfg_if.cfg_shape     = SHAPE_DC;
    cfg_if.cfg_step      = 16'h0800;
    cfg_if.cfg_amp       = 13'h0800;
    cfg_if.cfg_phase_rst = 1'b0;
    cfg_if.cfg_valid     = 1'b1;
    @(negedge clk);
    check("b_held_off", 32'(cfg_if.cfg_ready), 0);
    expect_tick(1'b1, 12'h100, 1'b0);
    i_tick = 1'b0;
    check("ready_after_apply", 32'(cfg_if.cfg_ready), 1);
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    check("b_accepted", 32'(cfg_if.cfg_ready), 0);
    idle(1);
    expect_tick(1'b1, 12'h400, 1'b0);
    idle(1);

    // Accept coincident with tick: that sample still uses config B.
    cfg_if.cfg_shape     = SHAPE_SAW;
    cfg_if.cfg_step      = 16'h2000;
    cfg_if.cfg_amp       = 13'h0800;
    cfg_if.cfg_phase_rst = 1'b0;
    cfg_if.cfg_valid     = 1'b1;
    expect_tick(1'b1, 12'h400, 1'b0);
    i_tick = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    check("c_accepted_on_tick", 32'(cfg_if.cfg_ready), 0);
    idle(1);
    expect_tick(1'b1, 12'h200, 1'b0);
    idle(2);

    // Phase reset applied while disabled: no strobe, next enabled tick starts from zero.
    send_cfg(SHAPE_SAW, 16'h1000, 13'h1000, 1'b1);
    i_enable = 1'b0;
    expect_tick(1'b0, 12'h000, 1'b0);
    idle(3);
    check("ready_after_disabled_apply", 32'(cfg_if.cfg_ready), 1);
    i_enable = 1'b1;
    expect_tick(1'b1, 12'h100, 1'b0);
    idle(2);

    // Phase reset applied while enabled: strobe with phase 0 and no wrap.
    send_cfg(SHAPE_SQUARE, 16'h4000, 13'h1000, 1'b1);
    expect_tick(1'b1, 12'h000, 1'b0);
    expect_tick(1'b1, 12'h000, 1'b0);
    expect_tick(1'b1, 12'hFFF, 1'b0);
    idle(2);

    // Gain above unity clamps to unity.
    send_cfg(SHAPE_SAW, 16'h1000, 13'h1FFF, 1'b0);
    expect_tick(1'b1, 12'h900, 1'b0);
    idle(1);
    expect_tick(1'b1, 12'hA00, 1'b0);
    expect_tick(1'b1, 12'hB00, 1'b0);
    idle(2);

    // Async reset mid-stream with a config pending.
    send_cfg(SHAPE_DC, 16'h4000, 13'h1000, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_sample", 32'(o_sample), 0);
    check("midrst_valid", 32'(o_sample_valid), 0);
    check("midrst_wrap", 32'(o_wrap), 0);
    check("midrst_ready", 32'(cfg_if.cfg_ready), 1);
    exp_q.delete();
    #3 rst_n = 1'b1;
    @(negedge clk);
    expect_tick(1'b1, 12'h000, 1'b0);
    idle(3);

    check("queue_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
